// File: rtl/noc_pkg.sv
// Shared NoC definitions for the ingress port and its flit FIFOs.
//   VC_BITS / FLIT_WIDTH : flit and virtual-channel widths
//   FLIT_VC_LSB          : position of the VC id inside a flit (just below valid)
//   credit_t             : credit return word {valid, vc}
package noc_pkg;

  localparam int unsigned VC_BITS     = 1;
  localparam int unsigned FLIT_WIDTH  = 16;
  localparam int unsigned FLIT_VC_LSB = FLIT_WIDTH - 1 - VC_BITS;

  typedef struct packed {
    logic               valid;
    logic [VC_BITS-1:0] vc;
  } credit_t;

endpackage

// File: rtl/flit_fifo.sv
// Single-clock 1R1W flit FIFO with full/empty flags.
//   CLK, RST_N    : clock, asynchronous active-low reset
//   wrEn, wrData  : push request and data
//   rdEn, rdData  : pop request and head-of-queue data
//   full, empty   : occupancy flags
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module flit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             wrAcc;
  logic             rdAcc;

  always_comb begin
    full   = (count == CW'(DEPTH));
    empty  = (count == '0);
    rdAcc  = rdEn && !empty;
    wrAcc  = wrEn && (!full || rdAcc);
    rdData = mem[rdPtr];
  end

  always_ff @(posedge CLK) begin
    if (wrAcc) mem[wrPtr] <= wrData;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrAcc) wrPtr <= wrPtr + PW'(1);
      if (rdAcc) rdPtr <= rdPtr + PW'(1);
      if (wrAcc && !rdAcc)      count <= count + CW'(1);
      else if (!wrAcc && rdAcc) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/network_ingress_port.sv
// Network-side receiver of a send port: buffers flits per virtual channel,
// forwards them round-robin over a valid/ready link and returns one credit
// per forwarded flit.
//   CLK, RST_N                   : clock, asynchronous active-low reset
//   send_ports_putFlit_flit_in   : incoming flit, MSB = valid
//   EN_send_ports_putFlit        : enqueue strobe
//   send_ports_getCredits        : credit {valid, vc}, lowest VC with pending credit
//   EN_send_ports_getCredits     : sender takes the presented credit
//   out_flit / out_flit_valid / out_flit_ready : downstream handshake
//   overflow_err                 : sticky, a flit arrived for a full VC
module network_ingress_port
  import noc_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned NUM_VCS   = 2 ** VC_BITS
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [FLIT_WIDTH-1:0] send_ports_putFlit_flit_in,
  input  logic                  EN_send_ports_putFlit,
  output logic [VC_BITS:0]      send_ports_getCredits,
  input  logic                  EN_send_ports_getCredits,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_flit_valid,
  input  logic                  out_flit_ready,
  output logic                  overflow_err
);

  localparam int unsigned CRW = $clog2(BUF_DEPTH + 1);

  logic [NUM_VCS-1:0]    fifoWr;
  logic [NUM_VCS-1:0]    fifoRd;
  logic [NUM_VCS-1:0]    fifoFull;
  logic [NUM_VCS-1:0]    fifoEmpty;
  logic [NUM_VCS-1:0]    crDec;
  logic [FLIT_WIDTH-1:0] fifoHead [NUM_VCS];
  logic [CRW-1:0]        pendingCr [NUM_VCS];

  logic [VC_BITS-1:0] inVc;
  logic [VC_BITS-1:0] rrPtr;
  logic [VC_BITS-1:0] rrSel;
  logic [VC_BITS-1:0] sel;
  logic [VC_BITS-1:0] heldVc;
  logic               holding;
  logic               putValid;
  logic               xfer;
  logic               crTake;
  logic               dropFlit;
  credit_t            credit;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    flit_fifo #(
      .DEPTH(BUF_DEPTH),
      .WIDTH(FLIT_WIDTH)
    ) uFifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .wrEn  (fifoWr[v]),
      .wrData(send_ports_putFlit_flit_in),
      .rdEn  (fifoRd[v]),
      .rdData(fifoHead[v]),
      .full  (fifoFull[v]),
      .empty (fifoEmpty[v])
    );
  end

  always_comb begin
    inVc     = send_ports_putFlit_flit_in[FLIT_VC_LSB +: VC_BITS];
    putValid = EN_send_ports_putFlit && send_ports_putFlit_flit_in[FLIT_WIDTH-1]
               && (32'(inVc) < NUM_VCS);
  end

  // Round-robin search starting at rrPtr (the VC after the last transfer).
  always_comb begin
    logic found;
    int unsigned idx;
    found = 1'b0;
    rrSel = rrPtr;
    for (int unsigned i = 0; i < NUM_VCS; i++) begin
      idx = (32'(rrPtr) + i) % NUM_VCS;
      if (!found && !fifoEmpty[idx]) begin
        found = 1'b1;
        rrSel = VC_BITS'(idx);
      end
    end
  end

  // A stalled offer stays pinned to its VC even if a higher-priority VC fills.
  always_comb begin
    sel            = holding ? heldVc : rrSel;
    out_flit_valid = ~&fifoEmpty;
    out_flit       = out_flit_valid ? fifoHead[sel] : '0;
    xfer           = out_flit_valid && out_flit_ready;
  end

  always_comb begin
    credit = '0;
    for (int unsigned i = 0; i < NUM_VCS; i++) begin
      if (!credit.valid && pendingCr[i] != '0) begin
        credit.valid = 1'b1;
        credit.vc    = VC_BITS'(i);
      end
    end
    send_ports_getCredits = credit;
    crTake                = EN_send_ports_getCredits && credit.valid;
  end

  always_comb begin
    fifoWr = '0;
    fifoRd = '0;
    crDec  = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      fifoWr[v] = putValid && (32'(inVc) == v);
      fifoRd[v] = xfer && (32'(sel) == v);
      crDec[v]  = crTake && (32'(credit.vc) == v);
    end
    dropFlit = putValid && fifoFull[inVc] && !fifoRd[inVc];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rrPtr        <= '0;
      holding      <= 1'b0;
      heldVc       <= '0;
      overflow_err <= 1'b0;
      for (int unsigned v = 0; v < NUM_VCS; v++) pendingCr[v] <= '0;
    end else begin
      holding <= out_flit_valid && !out_flit_ready;
      heldVc  <= sel;
      if (xfer) rrPtr <= VC_BITS'((32'(sel) + 1) % NUM_VCS);
      if (dropFlit) overflow_err <= 1'b1;
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        if (fifoRd[v] && !crDec[v])      pendingCr[v] <= pendingCr[v] + CRW'(1);
        else if (!fifoRd[v] && crDec[v]) pendingCr[v] <= pendingCr[v] - CRW'(1);
      end
    end
  end

endmodule

// File: tb/tb_network_ingress_port.sv
module tb_network_ingress_port;
  import noc_pkg::*;

  localparam int DEPTH = 4;
  localparam int NV    = 2;
  localparam int FW    = FLIT_WIDTH;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [FW-1:0] flitIn;
  logic          enPut;
  logic [VC_BITS:0] credits;
  logic          enCr;
  logic [FW-1:0] outFlit;
  logic          outValid;
  logic          outReady;
  logic          ovfErr;

  always #5 CLK = ~CLK;

  network_ingress_port #(
    .BUF_DEPTH(DEPTH),
    .NUM_VCS  (NV)
  ) dut (
    .CLK                       (CLK),
    .RST_N                     (RST_N),
    .send_ports_putFlit_flit_in(flitIn),
    .EN_send_ports_putFlit     (enPut),
    .send_ports_getCredits     (credits),
    .EN_send_ports_getCredits  (enCr),
    .out_flit                  (outFlit),
    .out_flit_valid            (outValid),
    .out_flit_ready            (outReady),
    .overflow_err              (ovfErr)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one queue per VC, outstanding credits per VC, and the
  // sender's view of how many flits it may still send on each VC.
  logic [FW-1:0] mq [NV][$];
  int  pend   [NV];
  int  sendCr [NV];
  bit  mOvf;
  bit  mStall;
  int  mHeldVc;
  int  mLastVc;
  int  xferCount = 0;

  function automatic logic [FW-1:0] mkFlit(input int vc, input int data);
    logic [FW-1:0] f;
    f = FW'(data);
    f[FW-1] = 1'b1;
    f[FLIT_VC_LSB +: VC_BITS] = VC_BITS'(vc);
    return f;
  endfunction

  task automatic modelReset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      pend[v]   = 0;
      sendCr[v] = DEPTH;
    end
    mOvf    = 1'b0;
    mStall  = 1'b0;
    mHeldVc = 0;
    mLastVc = NV - 1;
  endtask

  // Called just after a rising edge: drive, check at the falling edge,
  // advance the model, then step to just after the next rising edge.
  task automatic cycle(input bit put, input logic [FW-1:0] flit, input bit rdy, input bit take);
    int v, sz, expVc;
    bit expValid;
    logic [FW-1:0] expFlit;
    logic [VC_BITS:0] expCr;
    enPut = put; flitIn = flit; outReady = rdy; enCr = take;
    @(negedge CLK);
    expValid = 1'b0;
    expVc    = 0;
    for (int i = 0; i < NV; i++) if (mq[i].size() > 0) expValid = 1'b1;
    if (expValid) begin
      if (mStall) expVc = mHeldVc;
      else begin
        for (int i = 1; i <= NV; i++) begin
          int c;
          c = (mLastVc + i) % NV;
          if (mq[c].size() > 0) begin
            expVc = c;
            break;
          end
        end
      end
    end
    expFlit = expValid ? mq[expVc][0] : '0;
    expCr = '0;
    for (int i = NV - 1; i >= 0; i--) if (pend[i] > 0) expCr = {1'b1, VC_BITS'(i)};
    checkEq("out_valid", 32'(outValid), 32'(expValid));
    checkEq("out_flit", 32'(outFlit), 32'(expFlit));
    checkEq("credit", 32'(credits), 32'(expCr));
    checkEq("overflow", 32'(ovfErr), 32'(mOvf));

    v  = int'(flit[FLIT_VC_LSB +: VC_BITS]);
    sz = mq[v].size();
    if (expValid && rdy) begin
      void'(mq[expVc].pop_front());
      pend[expVc]++;
      mLastVc = expVc;
      xferCount++;
    end
    if (take && expCr[VC_BITS]) begin
      pend[int'(expCr[VC_BITS-1:0])]--;
      sendCr[int'(expCr[VC_BITS-1:0])]++;
    end
    if (put && flit[FW-1]) begin
      sendCr[v]--;
      if (sz < DEPTH || (expValid && rdy && expVc == v)) mq[v].push_back(flit);
      else mOvf = 1'b1;
    end
    mStall  = expValid && !rdy;
    mHeldVc = expVc;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input bit take);
    repeat (n) cycle(1'b0, '0, 1'b1, take);
  endtask

  task automatic doReset();
    enPut = 1'b0; flitIn = '0; outReady = 1'b0; enCr = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    checkEq("rst_valid", 32'(outValid), 0);
    checkEq("rst_flit", 32'(outFlit), 0);
    checkEq("rst_credit", 32'(credits), 0);
    checkEq("rst_overflow", 32'(ovfErr), 0);
    modelReset();
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [FW-1:0] f;
    int base;
    RST_N = 1'b0; enPut = 1'b0; flitIn = '0; outReady = 1'b0; enCr = 1'b0;
    modelReset();
    #12;
    checkEq("init_valid", 32'(outValid), 0);
    checkEq("init_flit", 32'(outFlit), 0);
    checkEq("init_credit", 32'(credits), 0);
    checkEq("init_overflow", 32'(ovfErr), 0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Single flit on VC0, then credit return and consumption.
    f = mkFlit(0, 'h123);
    cycle(1'b1, f, 1'b1, 1'b0);
    checkEq("single_valid", 32'(outValid), 1);
    checkEq("single_flit", 32'(outFlit), 32'(f));
    cycle(1'b0, '0, 1'b1, 1'b0);
    checkEq("single_credit", 32'(credits), 32'h2);
    cycle(1'b0, '0, 1'b1, 1'b1);
    checkEq("single_credit_gone", 32'(credits), 0);
    idle(2, 1'b0);

    // Five flits to VC1 while stalled: fifth dropped, error sticks.
    base = xferCount;
    for (int i = 0; i < 5; i++) cycle(1'b1, mkFlit(1, 'h40 + i), 1'b0, 1'b0);
    checkEq("ovf_set", 32'(ovfErr), 1);
    idle(8, 1'b1);
    checkEq("ovf_sticky", 32'(ovfErr), 1);
    checkEq("ovf_kept4", 32'(xferCount - base), 4);
    doReset();

    // Two flits per VC, interleaved on the way out.
    cycle(1'b1, mkFlit(0, 'h10), 1'b0, 1'b0);
    cycle(1'b1, mkFlit(0, 'h11), 1'b0, 1'b0);
    cycle(1'b1, mkFlit(1, 'h20), 1'b0, 1'b0);
    cycle(1'b1, mkFlit(1, 'h21), 1'b0, 1'b0);
    idle(7, 1'b1);

    // Full VC0 drained with ready toggling every cycle.
    base = xferCount;
    for (int i = 0; i < 4; i++) cycle(1'b1, mkFlit(0, 'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'(i % 2), 1'b1);
    checkEq("toggle_xfers", 32'(xferCount - base), 4);
    idle(5, 1'b1);

    // Full VC0, enqueue and dequeue in the same cycle.
    base = xferCount;
    for (int i = 0; i < 4; i++) cycle(1'b1, mkFlit(0, 'h90 + i), 1'b0, 1'b0);
    cycle(1'b1, mkFlit(0, 'h9f), 1'b1, 1'b0);
    checkEq("full_rw_ovf", 32'(ovfErr), 0);
    idle(10, 1'b1);
    checkEq("full_rw_xfers", 32'(xferCount - base), 5);
    idle(3, 1'b1);

    // Reset with three flits buffered and two credits pending.
    cycle(1'b1, mkFlit(0, 'h31), 1'b0, 1'b0);
    cycle(1'b1, mkFlit(0, 'h32), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, mkFlit(i % 2, 'h50 + i), 1'b0, 1'b0);
    checkEq("pre_rst_credit", 32'(credits), 32'h2);
    checkEq("pre_rst_valid", 32'(outValid), 1);
    doReset();
    checkEq("post_rst_valid", 32'(outValid), 0);

    // Randomized traffic under credit flow control.
    repeat (600) begin
      int v;
      bit put, vb, rdy, take;
      v    = int'($urandom_range(0, NV - 1));
      put  = ($urandom % 3) != 0;
      vb   = ($urandom % 8) != 0;
      rdy  = ($urandom % 4) != 0;
      take = ($urandom % 2) != 0;
      f = mkFlit(v, int'($urandom));
      if (!vb) f[FW-1] = 1'b0;
      if (put && vb && sendCr[v] <= 0) put = 1'b0;
      cycle(put, f, rdy, take);
    end
    idle(12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/network_ingress_port.md
NETWORK_INGRESS_PORT -- requirements
Module: network_ingress_port

Interface
REQ-001 Parameter BUF_DEPTH, default 4, flits buffered per VC (power of two, >=2).
REQ-002 Parameter NUM_VCS, default 2**`VC_BITS, number of virtual channels.
REQ-003 One clock; reset is asynchronous and active-low: CLK input, RST_N input.
REQ-004 send_ports_putFlit_flit_in  in  `FLIT_WIDTH  flit from device-side sender; bit FLIT_WIDTH-1 = valid.
REQ-005 EN_send_ports_putFlit  in  1  enqueue strobe for flit_in.
REQ-006 send_ports_getCredits  out  `VC_BITS+1  credit return; bit VC_BITS = valid, low bits = VC id.
REQ-007 EN_send_ports_getCredits  in  1  sender consumes the presented credit this cycle.
REQ-008 out_flit  out  `FLIT_WIDTH  head flit of the selected VC, valid bit included.
REQ-009 out_flit_valid  out  1 / out_flit_ready  in  1  downstream valid/ready handshake.
REQ-010 overflow_err  out  1  sticky error: flit arrived for a full VC.

Function
REQ-011 Network-side receiver of a send port: SHALL accept flits, buffer them per VC, forward them over valid/ready, and return one credit per forwarded flit.
REQ-012 Enqueue SHALL occur when EN_send_ports_putFlit=1 and flit_in valid bit=1, into the FIFO selected by the flit VC field (bits FLIT_VC_LSB+:VC_BITS).
REQ-013 EN with valid bit=0 SHALL be ignored: no enqueue, no error.
REQ-014 Enqueue into a full VC SHALL drop the flit, leave the FIFO unchanged, and set overflow_err from the next cycle until reset.
REQ-015 Latency SHALL be one cycle: a flit enqueued at edge N is visible on out_flit no earlier than cycle N+1; no combinational bypass.
REQ-016 out_flit_valid SHALL be 1 iff any VC FIFO is non-empty; a transfer occurs on out_flit_valid && out_flit_ready.
REQ-017 VC selection SHALL be round-robin, starting after the last-transferred VC; while out_flit_valid=1 and out_flit_ready=0, out_flit and the selected VC SHALL be held stable.
REQ-018 Each transfer from VC v SHALL increment pending_cr[v] (width clog2(BUF_DEPTH+1)).
REQ-019 send_ports_getCredits SHALL combinationally present the lowest-index VC with pending_cr>0, valid bit=1; if none, all bits 0.
REQ-020 EN_send_ports_getCredits with credit valid=1 SHALL decrement that VC's pending_cr; with valid=0 it is a no-op.
REQ-021 Transfer and credit consumption on the same VC in one cycle SHALL leave pending_cr unchanged.
REQ-022 Simultaneous enqueue and dequeue on the same VC SHALL succeed, including when that VC is full.
REQ-023 FIFO pointers SHALL wrap modulo BUF_DEPTH; occupancy SHALL never exceed BUF_DEPTH; pending_cr[v] + occupancy[v] SHALL never exceed BUF_DEPTH.

Reset
REQ-024 On RST_N=0: all FIFOs empty, pending_cr=0, round-robin pointer=VC 0, overflow_err=0, out_flit_valid=0, out_flit=0, send_ports_getCredits=0.
REQ-025 Reset mid-operation SHALL discard buffered flits and uncredited returns without emitting partial output.

Structure
REQ-026 FLIT_VC_LSB and a credit typedef (valid + VC id) SHALL live in the shared noc_pkg; widths come from `FLIT_WIDTH/`VC_BITS in connect_parameters.v.
REQ-027 One sub-module flit_fifo (depth BUF_DEPTH, 1R1W, full/empty flags) SHALL be instantiated NUM_VCS times.

Verification (VC_BITS=1, BUF_DEPTH=4)
REQ-028 Single flit VC0, ready=1 -> out_flit_valid next cycle, flit matches; getCredits=2'b10 the cycle after transfer; EN consumes, returns to 0.
REQ-029 Five flits VC1, ready=0 -> first four buffered, fifth dropped, overflow_err=1 next cycle and stays 1.
REQ-030 Two flits each on VC0 and VC1, ready=1 -> output order VC0,VC1,VC0,VC1; credits 2'b10,2'b10,2'b11,2'b11 when consumed one per cycle.
REQ-031 ready toggled 0/1 every cycle with VC0 full -> out_flit stable while stalled, four transfers, no loss or duplication.
REQ-032 Full VC0, enqueue and dequeue same cycle -> accepted, overflow_err stays 0, occupancy stays 4.
REQ-033 RST_N asserted with 3 flits buffered and 2 credits pending -> out_flit_valid=0, getCredits=0 immediately; clean operation after release.
